pulse_reader: RTL and testbench

Receive-side decoder for the switch-coded pulse link. It measures the high time of a single pulse on `pin`, counted in ticks of an internal prescaler, and classifies that width as one of the four switch codes. It reports the result as a held one-hot `code` together with a one-cycle `valid` or `err` strobe. It sits at the far end of the wire driven by the pulse transmitter and runs from the same `sysclk` domain and tick rate.

---
 rtl/pulse_reader.sv | 188 ++++++++++++++++++
 tb/tb_pulse_reader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_reader.sv
// pulse_reader: receive-side decoder for the switch-coded pulse link.
// Measures the high time of a pulse on pin in prescaler ticks and classifies
// it as one of four switch codes (sw1..sw4), reporting a held one-hot code
// and width plus a one-cycle valid or err strobe.
module pulse_reader #(
    parameter int DIV = 5207,
    parameter int CW  = 15,
    parameter int TOL = 3
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       pin,
    output logic [3:0] code,
    output logic [8:0] width,
    output logic       valid,
    output logic       err,
    output logic       busy
);

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        IDLE     = 2'd1,
        MEAS     = 2'd2,
        DECIDE   = 2'd3
    } state_t;

    // Nominal widths in ticks; index k maps to code bit k.
    localparam logic [3:0][9:0] REF_W = {10'd53, 10'd92, 10'd131, 10'd144};
    localparam logic [8:0]      COUNT_MAX = 9'd511;

    state_t          r_state;
    state_t          w_nextState;

    logic            r_pinSync1;
    logic            r_pinS;
    logic            r_pinPrev;
    logic            w_rise;
    logic            w_fall;

    logic [CW-1:0]   r_presc;
    logic            w_tick;

    logic [8:0]      r_count;
    logic [9:0]      w_count10;
    logic [3:0]      w_match;

    logic            w_clrCount;
    logic            w_incCount;
    logic            w_overflow;
    logic            w_decide;

    logic [3:0]      r_code;
    logic [8:0]      r_width;
    logic            r_valid;
    logic            r_err;

    assign w_rise    = r_pinS & ~r_pinPrev;
    assign w_fall    = ~r_pinS & r_pinPrev;
    assign w_tick    = (r_presc == CW'(DIV - 1));
    assign w_count10 = {1'b0, r_count};

    assign code  = r_code;
    assign width = r_width;
    assign valid = r_valid;
    assign err   = r_err;
    assign busy  = (r_state == MEAS);

    // Synchronizer and edge-detect flops; they reset high so a pulse already
    // in progress at reset release is seen as "line busy", not as a fresh rise.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_pinSync1 <= 1'b1;
            r_pinS     <= 1'b1;
            r_pinPrev  <= 1'b1;
        end else begin
            r_pinSync1 <= pin;
            r_pinS     <= r_pinSync1;
            r_pinPrev  <= r_pinS;
        end
    end

    // Free-running prescaler; wraps at DIV-1 and is never restarted by pulses.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + CW'(1);
        end
    end

    // State register.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WAIT_LOW;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic and datapath control strobes.
    always_comb begin
        w_nextState = r_state;
        w_clrCount  = 1'b0;
        w_incCount  = 1'b0;
        w_overflow  = 1'b0;
        w_decide    = 1'b0;
        case (r_state)
            WAIT_LOW: begin
                if (!r_pinS) begin
                    w_nextState = IDLE;
                end
            end
            IDLE: begin
                if (w_rise) begin
                    w_clrCount  = 1'b1;
                    w_nextState = MEAS;
                end
            end
            MEAS: begin
                if (w_fall) begin
                    w_nextState = DECIDE;
                end else if (r_count == COUNT_MAX) begin
                    w_overflow  = 1'b1;
                    w_nextState = WAIT_LOW;
                end else if (w_tick && r_pinS) begin
                    w_incCount = 1'b1;
                end
            end
            DECIDE: begin
                w_decide    = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = WAIT_LOW;
            end
        endcase
    end

    // Tick counter for the pulse being measured, saturating at 511.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_clrCount) begin
            r_count <= '0;
        end else if (w_incCount && (r_count != COUNT_MAX)) begin
            r_count <= r_count + 9'd1;
        end
    end

    // Window match against each reference width; windows are disjoint for TOL <= 6.
    always_comb begin
        w_match = '0;
        for (int k = 0; k < 4; k++) begin
            if ((w_count10 >= 10'(REF_W[k] - 10'(TOL))) &&
                (w_count10 <= 10'(REF_W[k] + 10'(TOL)))) begin
                w_match[k] = 1'b1;
            end
        end
    end

    // Result registers: code/width held, valid/err strobed for one cycle.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_code  <= '0;
            r_width <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (w_overflow) begin
                r_width <= COUNT_MAX;
                r_err   <= 1'b1;
            end else if (w_decide) begin
                r_width <= r_count;
                if (|w_match) begin
                    r_code  <= w_match;
                    r_valid <= 1'b1;
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pulse_reader.sv
// tb_pulse_reader: directed self-checking bench for pulse_reader (DIV=4, TOL=3).
// Pulses are driven as 4*ticks+1 sysclk high so the counted width equals the
// tick count exactly, independent of the free-running prescaler phase.
module tb_pulse_reader;

    logic       sysclk = 1'b0;
    logic       rst_n;
    logic       pin;
    logic [3:0] code;
    logic [8:0] width;
    logic       valid;
    logic       err;
    logic       busy;

    int errors = 0;
    int checks = 0;

    // Strobe observations collected by the monitor.
    int         nValid = 0;
    int         nErr   = 0;
    int         nBoth  = 0;
    logic [3:0] lastCode  = '0;
    logic [8:0] lastWidth = '0;

    // Bench copy of the prescaler phase: posedges since reset release.
    int cyc = 0;

    always #5 sysclk = ~sysclk;

    pulse_reader #(.DIV(4), .CW(3), .TOL(3)) dut (
        .sysclk(sysclk),
        .rst_n (rst_n),
        .pin   (pin),
        .code  (code),
        .width (width),
        .valid (valid),
        .err   (err),
        .busy  (busy)
    );

    // Record every strobe shortly after the edge that produced it.
    always @(posedge sysclk) begin
        #1;
        if (valid) begin
            nValid++;
            lastCode  = code;
            lastWidth = width;
        end
        if (err) begin
            nErr++;
            lastWidth = width;
        end
        if (valid && err) begin
            nBoth++;
        end
    end

    // Track the prescaler phase from the bench side.
    always @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Drive one pulse of the given tick count, then let the decision settle.
    task automatic applyStimulus(input int ticks);
        @(negedge sysclk);
        pin = 1'b1;
        repeat (4 * ticks + 1) @(negedge sysclk);
        pin = 1'b0;
        repeat (8) @(negedge sysclk);
    endtask

    // Reset values, pulse already high at release ignored, then a sw4 pulse.
    task automatic test_reset;
        int v0;
        pin   = 1'b1;
        rst_n = 1'b0;
        #23;
        checks++; if (code !== 4'b0000) begin errors++; $display("FAIL reset_code: got %b expected 0000", code); end
        checks++; if (width !== 9'd0) begin errors++; $display("FAIL reset_width: got %0d expected 0", width); end
        checks++; if ({valid, err, busy} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b expected 000", {valid, err, busy}); end
        @(negedge sysclk);
        rst_n = 1'b1;
        repeat (40) @(negedge sysclk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_high_busy: got %b expected 0", busy); end
        pin = 1'b0;
        repeat (10) @(negedge sysclk);
        checks++; if (nValid + nErr !== 0) begin errors++; $display("FAIL held_high_strobe: got %0d strobes expected 0", nValid + nErr); end
        v0 = nValid;
        applyStimulus(53);
        checks++; if (nValid !== v0 + 1) begin errors++; $display("FAIL first53_valid: got %0d expected %0d", nValid, v0 + 1); end
        checks++; if (code !== 4'b1000) begin errors++; $display("FAIL first53_code: got %b expected 1000", code); end
        checks++; if (width !== 9'd53) begin errors++; $display("FAIL first53_width: got %0d expected 53", width); end
    endtask

    // Cycle-exact rise->busy and fall->valid latency on a sw3 pulse.
    task automatic test_latency;
        @(negedge sysclk);
        pin = 1'b1;
        repeat (2) @(negedge sysclk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_early: got %b expected 0", busy); end
        @(negedge sysclk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_at3: got %b expected 1", busy); end
        repeat (4 * 92 + 1 - 3) @(negedge sysclk);
        pin = 1'b0;
        repeat (3) @(negedge sysclk);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL valid_early: got %b expected 0", valid); end
        @(negedge sysclk);
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL valid_at4: got %b expected 1", valid); end
        checks++; if (code !== 4'b0100) begin errors++; $display("FAIL lat_code: got %b expected 0100", code); end
        checks++; if (width !== 9'd92) begin errors++; $display("FAIL lat_width: got %0d expected 92", width); end
        @(negedge sysclk);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL valid_one_cycle: got %b expected 0", valid); end
        repeat (4) @(negedge sysclk);
    endtask

    // All four nominal codes in sequence.
    task automatic test_codes;
        int         ticksTab [4] = '{144, 131, 92, 53};
        logic [3:0] codeTab  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        int v0;
        for (int i = 0; i < 4; i++) begin
            v0 = nValid;
            applyStimulus(ticksTab[i]);
            checks++; if (nValid !== v0 + 1) begin errors++; $display("FAIL seq_valid[%0d]: got %0d expected %0d", i, nValid, v0 + 1); end
            checks++; if (code !== codeTab[i]) begin errors++; $display("FAIL seq_code[%0d]: got %b expected %b", i, code, codeTab[i]); end
            checks++; if (width !== 9'(ticksTab[i])) begin errors++; $display("FAIL seq_width[%0d]: got %0d expected %0d", i, width, ticksTab[i]); end
        end
    endtask

    // Window edges with TOL=3: 128 and 147 accepted, 110 and 49 rejected.
    task automatic test_boundary;
        int         ticksTab [4] = '{128, 147, 110, 49};
        bit         okTab    [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [3:0] codeTab  [4] = '{4'b0010, 4'b0001, 4'b0001, 4'b0001};
        int v0, e0;
        for (int i = 0; i < 4; i++) begin
            v0 = nValid;
            e0 = nErr;
            applyStimulus(ticksTab[i]);
            checks++;
            if ((nValid - v0) !== (okTab[i] ? 1 : 0) || (nErr - e0) !== (okTab[i] ? 0 : 1)) begin
                errors++;
                $display("FAIL bound_strobe[%0d]: got valid+%0d err+%0d expected valid+%0d err+%0d",
                         ticksTab[i], nValid - v0, nErr - e0, okTab[i] ? 1 : 0, okTab[i] ? 0 : 1);
            end
            checks++; if (code !== codeTab[i]) begin errors++; $display("FAIL bound_code[%0d]: got %b expected %b", ticksTab[i], code, codeTab[i]); end
            checks++; if (width !== 9'(ticksTab[i])) begin errors++; $display("FAIL bound_width[%0d]: got %0d expected %0d", ticksTab[i], width, ticksTab[i]); end
        end
    endtask

    // 600-tick pulse saturates: one err at 511, silent fall, then normal decode.
    task automatic test_overflow;
        int v0, e0;
        v0 = nValid;
        e0 = nErr;
        @(negedge sysclk);
        pin = 1'b1;
        repeat (2400) @(negedge sysclk);
        checks++; if (nErr !== e0 + 1) begin errors++; $display("FAIL ovf_err: got %0d expected %0d", nErr, e0 + 1); end
        checks++; if (width !== 9'd511) begin errors++; $display("FAIL ovf_width: got %0d expected 511", width); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovf_busy: got %b expected 0", busy); end
        checks++; if (code !== 4'b0001) begin errors++; $display("FAIL ovf_code: got %b expected 0001", code); end
        pin = 1'b0;
        repeat (10) @(negedge sysclk);
        checks++; if (nErr !== e0 + 1 || nValid !== v0) begin errors++; $display("FAIL ovf_fall: got err=%0d valid=%0d expected err=%0d valid=%0d", nErr, nValid, e0 + 1, v0); end
        applyStimulus(92);
        checks++; if (nValid !== v0 + 1) begin errors++; $display("FAIL ovf_next_valid: got %0d expected %0d", nValid, v0 + 1); end
        checks++; if (code !== 4'b0100) begin errors++; $display("FAIL ovf_next_code: got %b expected 0100", code); end
    endtask

    // Two-sysclk glitch placed away from a tick gives err with width 0.
    task automatic test_glitch;
        int v0, e0;
        bit aligned;
        v0 = nValid;
        e0 = nErr;
        aligned = 1'b0;
        for (int i = 0; i < 8 && !aligned; i++) begin
            @(negedge sysclk);
            if (cyc % 4 == 2) aligned = 1'b1;
        end
        checks++; if (!aligned) begin errors++; $display("FAIL glitch_align: got no phase match expected match within 8 cycles"); end
        pin = 1'b1;
        repeat (2) @(negedge sysclk);
        pin = 1'b0;
        repeat (8) @(negedge sysclk);
        checks++; if (nErr !== e0 + 1 || nValid !== v0) begin errors++; $display("FAIL glitch_err: got err=%0d valid=%0d expected err=%0d valid=%0d", nErr, nValid, e0 + 1, v0); end
        checks++; if (width !== 9'd0) begin errors++; $display("FAIL glitch_width: got %0d expected 0", width); end
        checks++; if (code !== 4'b0100) begin errors++; $display("FAIL glitch_code: got %b expected 0100", code); end
    endtask

    // Pulses separated by a 3-cycle low gap are both decoded.
    task automatic test_back_to_back;
        int v0, e0;
        v0 = nValid;
        e0 = nErr;
        @(negedge sysclk);
        pin = 1'b1;
        repeat (4 * 131 + 1) @(negedge sysclk);
        pin = 1'b0;
        repeat (3) @(negedge sysclk);
        pin = 1'b1;
        repeat (4 * 53 + 1) @(negedge sysclk);
        pin = 1'b0;
        repeat (8) @(negedge sysclk);
        checks++; if (nValid !== v0 + 2 || nErr !== e0) begin errors++; $display("FAIL b2b_count: got valid=%0d err=%0d expected valid=%0d err=%0d", nValid, nErr, v0 + 2, e0); end
        checks++; if (code !== 4'b1000) begin errors++; $display("FAIL b2b_code: got %b expected 1000", code); end
        checks++; if (width !== 9'd53) begin errors++; $display("FAIL b2b_width: got %0d expected 53", width); end
    endtask

    // Reset mid-measurement clears outputs at once; the rest of the pulse is ignored.
    task automatic test_reset_mid;
        int v0, e0;
        v0 = nValid;
        e0 = nErr;
        @(negedge sysclk);
        pin = 1'b1;
        repeat (4 * 70) @(negedge sysclk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_reset: got %b expected 0", busy); end
        checks++; if (code !== 4'b0000 || width !== 9'd0) begin errors++; $display("FAIL mid_outputs_reset: got code=%b width=%0d expected 0000/0", code, width); end
        checks++; if ({valid, err} !== 2'b00) begin errors++; $display("FAIL mid_strobe_reset: got %b expected 00", {valid, err}); end
        repeat (2) @(negedge sysclk);
        rst_n = 1'b1;
        repeat (200) @(negedge sysclk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_after: got %b expected 0", busy); end
        pin = 1'b0;
        repeat (10) @(negedge sysclk);
        checks++; if (nValid !== v0 || nErr !== e0) begin errors++; $display("FAIL mid_no_strobe: got valid=%0d err=%0d expected valid=%0d err=%0d", nValid, nErr, v0, e0); end
    endtask

    // Run every scenario in order and report.
    initial begin
        pin   = 1'b0;
        rst_n = 1'b1;
        test_reset;
        test_latency;
        test_codes;
        test_boundary;
        test_overflow;
        test_glitch;
        test_back_to_back;
        test_reset_mid;
        checks++; if (nBoth !== 0) begin errors++; $display("FAIL valid_err_overlap: got %0d cycles expected 0", nBoth); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
